// File: rtl/wb_write_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_port_arbiter
//
// This block is the only writer into the register file's single write port.
// It merges two sources:
//   - Single-cycle MEM_WB results. These always win the port and have no
//     backpressure.
//   - Long-latency results, for example from a divider. These are buffered in
//     an in-order FIFO with DEPTH entries and drain only on cycles when the
//     pipeline does not write.
// It also tells the hazard unit which destinations are still waiting in the
// FIFO, and asks for a pipeline bubble when the FIFO is being starved.
//
// Ports
//   i_clk, i_rst            clock; synchronous active-high reset
//   i_pipe_valid/rd/data    MEM_WB write request (rd == 0 is discarded)
//   i_lat_valid/rd/data     long-latency result; handshake = valid & o_lat_ready
//   o_lat_ready             FIFO has room (from the registered count only)
//   o_RegWrite/o_rd/o_Rd    registered register-file write enable/index/value
//   i_query_rs1/rs2         hazard query indices
//   o_pend_hit1/2           the query index is targeted by a queued entry
//   o_stall_req             FIFO starved for STARVE_LIMIT cycles; drain needed
//   o_err_waw               sticky: pipe wrote an index that is still queued
// -----------------------------------------------------------------------------
module wb_write_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned IDX_W        = 5,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pipe_valid,
    input  logic [IDX_W-1:0] i_pipe_rd,
    input  logic [XLEN-1:0]  i_pipe_data,
    input  logic             i_lat_valid,
    input  logic [IDX_W-1:0] i_lat_rd,
    input  logic [XLEN-1:0]  i_lat_data,
    output logic             o_lat_ready,
    output logic             o_RegWrite,
    output logic [IDX_W-1:0] o_rd,
    output logic [XLEN-1:0]  o_Rd,
    input  logic [IDX_W-1:0] i_query_rs1,
    input  logic [IDX_W-1:0] i_query_rs2,
    output logic             o_pend_hit1,
    output logic             o_pend_hit2,
    output logic             o_stall_req,
    output logic             o_err_waw
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    // FIFO storage and state
    logic [IDX_W-1:0] r_fifo_rd   [DEPTH];
    logic [XLEN-1:0]  r_fifo_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Output and status registers
    logic             r_RegWrite;
    logic [IDX_W-1:0] r_rd;
    logic [XLEN-1:0]  r_Rd;
    logic [STV_W-1:0] r_starve;
    logic             r_stall;
    logic             r_err;

    // Combinational decode
    logic             w_pipe_win;
    logic             w_empty;
    logic             w_lat_ready;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [STV_W-1:0] w_starve_d;
    logic             w_hit1;
    logic             w_hit2;
    logic             w_hit_pipe;

    always_comb begin
        w_pipe_win  = i_pipe_valid && (i_pipe_rd != '0);
        w_empty     = (r_count == '0);
        w_lat_ready = (r_count < DEPTH_C);
        // A handshake with rd == 0 still completes, but nothing is stored.
        w_push      = i_lat_valid && w_lat_ready && (i_lat_rd != '0);
        w_pop       = !w_pipe_win && !w_empty;

        // The pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
        w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
        w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);

        // The FIFO is non-empty and no pop happens only when the pipe owns
        // the port. So counting "not drained" is the same as counting
        // "blocked by the pipe".
        w_starve_d = r_starve;
        if (w_empty || w_pop) begin
            w_starve_d = '0;
        end else if (r_starve != STV_MAX) begin
            w_starve_d = r_starve + STV_W'(1);
        end
    end

    // Compare each query against the destinations still queued.
    always_comb begin
        w_hit1     = 1'b0;
        w_hit2     = 1'b0;
        w_hit_pipe = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                if (r_fifo_rd[i] == i_query_rs1) w_hit1 = 1'b1;
                if (r_fifo_rd[i] == i_query_rs2) w_hit2 = 1'b1;
                if (r_fifo_rd[i] == i_pipe_rd)   w_hit_pipe = 1'b1;
            end
        end
    end

    // FIFO payload needs no reset: r_valid and r_count qualify it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_rd[r_wr_ptr]   <= i_lat_rd;
            r_fifo_data[r_wr_ptr] <= i_lat_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_RegWrite <= 1'b0;
            r_rd       <= '0;
            r_Rd       <= '0;
            r_starve   <= '0;
            r_stall    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= w_wr_ptr_nxt;
            end
            // Push targets the tail slot and pop the head slot. Both happen
            // together only when the FIFO is neither empty nor full, so the
            // two slots are always different.
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= w_rd_ptr_nxt;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (w_pipe_win) begin
                r_RegWrite <= 1'b1;
                r_rd       <= i_pipe_rd;
                r_Rd       <= i_pipe_data;
            end else if (w_pop) begin
                r_RegWrite <= 1'b1;
                r_rd       <= r_fifo_rd[r_rd_ptr];
                r_Rd       <= r_fifo_data[r_rd_ptr];
            end else begin
                r_RegWrite <= 1'b0;
            end

            r_starve <= w_starve_d;
            r_stall  <= (w_starve_d == STV_MAX);

            if (w_pipe_win && w_hit_pipe) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        o_lat_ready = w_lat_ready;
        o_RegWrite  = r_RegWrite;
        o_rd        = r_rd;
        o_Rd        = r_Rd;
        o_pend_hit1 = w_hit1 && (i_query_rs1 != '0);
        o_pend_hit2 = w_hit2 && (i_query_rs2 != '0);
        o_stall_req = r_stall;
        o_err_waw   = r_err;
    end

endmodule
